// File: rtl/cntr8_cmd_ctrl.sv
// Command controller for an external 3-bit counter: turns LOAD / INC-burst
// commands into single-cycle load/inc strobes, with done and wrap pulses.
module cntr8_cmd_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [2:0] cmd_data,
  input  logic       abort,
  input  logic [2:0] cnt_state,
  output logic       load,
  output logic       inc,
  output logic [2:0] d_out,
  output logic       busy,
  output logic       done,
  output logic       wrap
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_INC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     r_state;
  logic [3:0] r_rem;
  logic [2:0] r_dout;
  logic       r_load;
  logic       r_inc_en;
  logic       r_busy;
  logic       r_done;
  logic       r_wrap;
  logic       w_accept;
  logic       w_inc;

  assign cmd_ready = (r_state == S_IDLE) && !reset;
  assign w_accept  = cmd_valid && cmd_ready;
  // abort suppresses the strobe in the same cycle; reset cuts strobes at once
  assign w_inc     = r_inc_en && !abort && !reset;

  assign load  = r_load && !reset;
  assign inc   = w_inc;
  assign d_out = r_dout;
  assign busy  = r_busy;
  assign done  = r_done;
  assign wrap  = r_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_rem    <= 4'd0;
      r_dout   <= 3'd0;
      r_load   <= 1'b0;
      r_inc_en <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_wrap   <= w_inc && (cnt_state == 3'b111);
      r_load   <= 1'b0;
      r_inc_en <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_busy <= 1'b1;
            if (!cmd_op) begin
              r_dout  <= cmd_data;
              r_load  <= 1'b1;
              r_state <= S_LOAD;
            end else begin
              r_rem    <= (cmd_data == 3'd0) ? 4'd8 : {1'b0, cmd_data};
              r_inc_en <= 1'b1;
              r_state  <= S_INC;
            end
          end
        end
        S_LOAD: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_INC: begin
          if (abort || (r_rem == 4'd1)) begin
            r_rem   <= 4'd0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_rem    <= r_rem - 4'd1;
            r_inc_en <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cntr8_cmd_ctrl.sv
// Scoreboard bench: stimulus pushes expected strobe cycles, monitor pops and
// compares on every cycle where load/inc/done/wrap is active.
module tb_cntr8_cmd_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_op = 1'b0;
  logic [2:0] cmd_data = 3'd0;
  logic       abort = 1'b0;
  logic [2:0] cnt_state;
  logic       cmd_ready, load, inc, busy, done, wrap;
  logic [2:0] d_out;

  always #5 clk = ~clk;

  cntr8_cmd_ctrl dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .abort(abort), .cnt_state(cnt_state),
    .load(load), .inc(inc), .d_out(d_out), .busy(busy), .done(done), .wrap(wrap)
  );

  // the counter register being controlled
  always @(posedge clk) begin
    if (reset)     cnt_state <= 3'd0;
    else if (load) cnt_state <= d_out;
    else if (inc)  cnt_state <= cnt_state + 3'd1;
  end

  typedef struct packed {
    logic       ld, in, dn, wr;
    logic [2:0] d;
    logic       bsy;
    logic [7:0] gap;   // cycles since previous active cycle; 0 = don't care
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_pass = 0;

  function automatic void chk(string name, int act, int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endfunction

  task automatic push(input logic ld, input logic in, input logic dn, input logic wr,
                      input logic [2:0] d, input logic bsy, input logic [7:0] gap);
    exp_t e;
    e.ld = ld; e.in = in; e.dn = dn; e.wr = wr; e.d = d; e.bsy = bsy; e.gap = gap;
    q.push_back(e);
  endtask

  int cyc = 0, last = 0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!reset && (load || inc || done || wrap)) begin
      if (q.size() == 0) begin
        chk("sb_unexpected", {load, inc, done, wrap}, 0);
      end else begin
        e = q.pop_front();
        chk("sb_load", load, e.ld);
        chk("sb_inc", inc, e.in);
        chk("sb_done", done, e.dn);
        chk("sb_wrap", wrap, e.wr);
        chk("sb_d_out", d_out, e.d);
        chk("sb_busy", busy, e.bsy);
        if (e.gap != 8'd0) chk("sb_gap", cyc - last, e.gap);
      end
      last = cyc;
    end
  end

  task automatic issue(input logic op, input logic [2:0] data);
    int t = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    chk("accept_timeout", t < 50, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    chk("idle_timeout", t < 50, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst_load", load, 0);   chk("rst_inc", inc, 0);
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_wrap", wrap, 0);   chk("rst_d_out", d_out, 0);
    chk("rst_ready", cmd_ready, 0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk); chk("post_rst_ready", cmd_ready, 1);
    @(posedge clk); #1;

    // LOAD 101: load cycle, done cycle, ready again on the third cycle
    push(1, 0, 0, 0, 3'd5, 1, 0); push(0, 0, 1, 0, 3'd5, 0, 1);
    issue(1'b0, 3'd5);
    @(negedge clk); chk("ld_ready_c1", cmd_ready, 0);
    @(negedge clk); chk("ld_ready_c2", cmd_ready, 0);
    @(negedge clk); chk("ld_ready_c3", cmd_ready, 1);
    @(posedge clk); #1;

    // LOAD 0 then INC 3: counter 0 -> 3, no wrap
    push(1, 0, 0, 0, 3'd0, 1, 0); push(0, 0, 1, 0, 3'd0, 0, 1);
    issue(1'b0, 3'd0); wait_idle();
    push(0, 1, 0, 0, 3'd0, 1, 0); push(0, 1, 0, 0, 3'd0, 1, 1);
    push(0, 1, 0, 0, 3'd0, 1, 1); push(0, 0, 1, 0, 3'd0, 0, 1);
    issue(1'b1, 3'd3); wait_idle();

    // LOAD 6 then INC 0 (=8): 2nd inc is at 7, so wrap lands on the 3rd inc cycle
    push(1, 0, 0, 0, 3'd6, 1, 0); push(0, 0, 1, 0, 3'd6, 0, 1);
    issue(1'b0, 3'd6); wait_idle();
    push(0, 1, 0, 0, 3'd6, 1, 0); push(0, 1, 0, 0, 3'd6, 1, 1);
    push(0, 1, 0, 1, 3'd6, 1, 1);
    repeat (5) push(0, 1, 0, 0, 3'd6, 1, 1);
    push(0, 0, 1, 0, 3'd6, 0, 1);
    issue(1'b1, 3'd0); wait_idle();

    // INC 5 aborted on the 2nd inc cycle: one inc, then done
    push(0, 1, 0, 0, 3'd6, 1, 0); push(0, 0, 1, 0, 3'd6, 0, 2);
    issue(1'b1, 3'd5);
    @(posedge clk); #1; abort = 1'b1;
    @(negedge clk); chk("abort_inc", inc, 0); chk("abort_busy", busy, 1);
    @(posedge clk); #1; abort = 1'b0;
    wait_idle();

    // INC 4 from 7 with reset on the 3rd cycle
    push(0, 1, 0, 0, 3'd6, 1, 0); push(0, 1, 0, 1, 3'd6, 1, 1);
    issue(1'b1, 3'd4);
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk); chk("midrst_ready", cmd_ready, 0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("midrst_inc", inc, 0);  chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0); chk("midrst_ready_after", cmd_ready, 1);
    chk("midrst_d_out", d_out, 0);
    @(posedge clk); #1;

    // back-pressure: INC 2 held valid (abort held too) during LOAD 2
    push(1, 0, 0, 0, 3'd2, 1, 0); push(0, 0, 1, 0, 3'd2, 0, 1);
    push(0, 1, 0, 0, 3'd2, 1, 2); push(0, 1, 0, 0, 3'd2, 1, 1);
    push(0, 0, 1, 0, 3'd2, 0, 1);
    issue(1'b0, 3'd2);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_data = 3'd2; abort = 1'b1;
    @(negedge clk); chk("bp_ready_c1", cmd_ready, 0);
    @(negedge clk); chk("bp_ready_c2", cmd_ready, 0);
    @(negedge clk); chk("bp_ready_c3", cmd_ready, 1);
    @(posedge clk); #1; cmd_valid = 1'b0; abort = 1'b0;
    wait_idle();
    repeat (3) begin @(posedge clk); #1; end

    chk("sb_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
